// File: rtl/lzw_dict_ctrl.sv
// lzw_dict_ctrl: sequencer for the LZW dictionary RAM.
// Clears the table, serves one lookup/insert per handshake, and allocates codes.
module lzw_dict_ctrl #(
    parameter int ADDR_W     = 18,
    parameter int CHAR_W     = 8,
    parameter int CODE_W     = 12,
    parameter int FIRST_CODE = 256,
    parameter int MAX_CODES  = 2 ** (ADDR_W - CHAR_W)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ready,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqOp,
    input  logic [CODE_W-1:0] ReqPrefix,
    input  logic [CHAR_W-1:0] ReqChar,
    output logic              RspValid,
    output logic              RspHit,
    output logic [CODE_W-1:0] RspCode,
    output logic [CODE_W-1:0] NextCode,
    output logic              Full,
    output logic              RAMread,
    output logic              RAMZeroData,
    output logic              WriteString,
    output logic [ADDR_W-1:0] ramDicPointer,
    output logic [15:0]       ramString,
    input  logic [15:0]       iRAMData
);
    typedef enum logic [2:0] {WAIT, CLEAR, IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_nx;
    logic unused_bits;

    assign unused_bits = ^{ReqPrefix[CODE_W-1:ADDR_W-CHAR_W], iRAMData[14:CODE_W]};
    assign Full        = NextCode == CODE_W'(MAX_CODES);
    assign Ready       = state inside {IDLE, READ, WRITE, RESP};
    assign ReqReady    = state == IDLE && !Start;
    assign RspValid    = state == RESP;
    assign RAMZeroData = state == CLEAR;
    assign RAMread     = state == READ;
    assign WriteString = state == WRITE;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= WAIT;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            WAIT:        state_nx = Start ? CLEAR : WAIT;
            CLEAR:       state_nx = &ramDicPointer ? IDLE : CLEAR;
            IDLE:        state_nx = Start ? CLEAR : !ReqValid ? IDLE : !ReqOp ? READ : Full ? RESP : WRITE;
            READ, WRITE: state_nx = RESP;
            RESP:        state_nx = IDLE;
            default:     state_nx = WAIT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ramDicPointer <= '0;
            ramString     <= '0;
            RspHit        <= 1'b0;
            RspCode       <= '0;
            NextCode      <= CODE_W'(FIRST_CODE);
        end else begin
            case (state)
                WAIT, IDLE: begin
                    if (Start) begin
                        ramDicPointer <= '0;
                        NextCode      <= CODE_W'(FIRST_CODE);
                    end else if (state == IDLE && ReqValid) begin
                        ramDicPointer <= {ReqPrefix[ADDR_W-CHAR_W-1:0], ReqChar};
                        if (ReqOp && !Full) ramString <= 16'h8000 | 16'(NextCode);
                        // a full table answers an insert with a miss and an all-ones code
                        if (ReqOp && Full) begin
                            RspHit  <= 1'b0;
                            RspCode <= '1;
                        end
                    end
                end
                CLEAR: ramDicPointer <= ramDicPointer + ADDR_W'(1);
                READ: begin
                    RspHit  <= iRAMData[15];
                    RspCode <= iRAMData[15] ? iRAMData[CODE_W-1:0] : '0;
                end
                WRITE: begin
                    RspHit   <= 1'b0;
                    RspCode  <= NextCode;
                    NextCode <= NextCode + CODE_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// tb_lzw_dict_ctrl: self-checking bench with a RAM model and an associative-array dictionary model.
// Uses a reduced address width (12 bits, 2-bit chars) so table clears stay short.
module tb_lzw_dict_ctrl;
    localparam int AW = 12, CW = 2, KW = 12;
    logic          Clk, Reset, Start, Ready, ReqValid, ReqReady, ReqOp;
    logic [KW-1:0] ReqPrefix, RspCode, NextCode;
    logic [CW-1:0] ReqChar;
    logic          RspValid, RspHit, Full, RAMread, RAMZeroData, WriteString;
    logic [AW-1:0] ramDicPointer;
    logic [15:0]   ramString, iRAMData;
    logic [15:0]   mem [0:(1<<AW)-1];

    int vectors = 0, miscompares = 0;
    int dict [int];
    int next_code = 256;

    lzw_dict_ctrl #(.ADDR_W(AW), .CHAR_W(CW), .CODE_W(KW), .FIRST_CODE(256), .MAX_CODES(1024)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ready(Ready), .ReqValid(ReqValid),
        .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqPrefix(ReqPrefix), .ReqChar(ReqChar),
        .RspValid(RspValid), .RspHit(RspHit), .RspCode(RspCode), .NextCode(NextCode),
        .Full(Full), .RAMread(RAMread), .RAMZeroData(RAMZeroData), .WriteString(WriteString),
        .ramDicPointer(ramDicPointer), .ramString(ramString), .iRAMData(iRAMData)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    always @(posedge Clk)
        if (WriteString) mem[ramDicPointer] <= ramString;
        else if (RAMZeroData) mem[ramDicPointer] <= 16'h0;
    assign iRAMData = mem[ramDicPointer];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_run();
        int bad = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            if (!RAMZeroData || RAMread || WriteString || ramDicPointer !== AW'(i) ||
                Ready || RspValid || ReqReady) bad++;
            Start = (i == 100);
            @(negedge Clk);
        end
        Start = 0;
        check("clear_sequence", bad, 0);
        check("ready_after_clear", Ready, 1);
        check("zero_strobe_off", RAMZeroData, 0);
        check("next_after_clear", NextCode, 12'h100);
        dict.delete();
        next_code = 256;
    endtask

    task automatic do_clear();
        Start = 1;
        @(negedge Clk);
        Start = 0;
        clear_run();
    endtask

    // one full handshake, checked cycle by cycle against the dictionary model
    task automatic xact(input logic op, input logic [KW-1:0] p, input logic [CW-1:0] c,
                        output logic hit, output logic [KW-1:0] code);
        int key;
        logic eh, full_m;
        logic [KW-1:0] ec;
        key = int'({p[AW-CW-1:0], c});
        full_m = next_code >= 1024;
        if (!op) begin
            eh = dict.exists(key);
            ec = eh ? KW'(dict[key]) : '0;
        end else begin
            eh = 0;
            ec = full_m ? 12'hFFF : KW'(next_code);
        end
        ReqValid = 1; ReqOp = op; ReqPrefix = p; ReqChar = c;
        #1 check("req_ready", ReqReady, 1);
        @(negedge Clk);
        ReqValid = 0;
        check("read_strobe", RAMread, 32'(!op));
        check("write_strobe", WriteString, 32'(op && !full_m));
        if (!(op && full_m)) begin
            check("pointer", ramDicPointer, key);
            if (op) check("write_data", ramString, 16'h8000 | 16'(next_code));
            check("early_rsp", RspValid, 0);
            @(negedge Clk);
        end
        check("rsp_valid", RspValid, 1);
        hit = RspHit;
        code = RspCode;
        check("rsp_hit", hit, eh);
        check("rsp_code", code, ec);
        if (op && !full_m) begin
            dict[key] = next_code;
            next_code++;
        end
        check("next_code", NextCode, next_code);
        check("full", Full, 32'(next_code == 1024));
        @(negedge Clk);
        check("rsp_one_cycle", RspValid, 0);
    endtask

    typedef struct {
        logic          op;
        logic [KW-1:0] p;
        logic [CW-1:0] c;
        logic          hit;
        logic [KW-1:0] code;
        logic [KW-1:0] next;
    } vec_t;
    vec_t tbl [8];

    initial begin
        logic h;
        logic [KW-1:0] cd;
        int bad;
        tbl[0] = '{0, 12'h041, 2'd2, 0, 12'h000, 12'h100};
        tbl[1] = '{1, 12'h041, 2'd2, 0, 12'h100, 12'h101};
        tbl[2] = '{0, 12'h041, 2'd2, 1, 12'h100, 12'h101};
        tbl[3] = '{1, 12'h041, 2'd3, 0, 12'h101, 12'h102};
        tbl[4] = '{0, 12'h441, 2'd3, 1, 12'h101, 12'h102};
        tbl[5] = '{0, 12'h041, 2'd1, 0, 12'h000, 12'h102};
        tbl[6] = '{1, 12'h3FF, 2'd0, 0, 12'h102, 12'h103};
        tbl[7] = '{0, 12'hFFF, 2'd0, 1, 12'h102, 12'h103};

        Reset = 1; Start = 0; ReqValid = 0; ReqOp = 0; ReqPrefix = 0; ReqChar = 0;
        #1;
        check("rst_ready", Ready, 0);
        check("rst_req_ready", ReqReady, 0);
        check("rst_next", NextCode, 12'h100);
        check("rst_strobes", {RAMread, RAMZeroData, WriteString, RspValid, RspHit, Full}, 0);
        check("rst_data", {RspCode, ramDicPointer, ramString}, 0);
        @(negedge Clk); @(negedge Clk);
        Reset = 0;

        Start = 1;
        @(negedge Clk);
        Start = 0;
        repeat (50) @(negedge Clk);
        check("mid_clear_active", RAMZeroData, 1);
        #2 Reset = 1;
        #1;
        check("async_rst_zero", RAMZeroData, 0);
        check("async_rst_ptr", ramDicPointer, 0);
        check("async_rst_ready", Ready, 0);
        @(negedge Clk);
        #2 Reset = 0;
        @(negedge Clk);
        check("wait_no_clear", RAMZeroData, 0);
        do_clear();

        foreach (tbl[i]) begin
            xact(tbl[i].op, tbl[i].p, tbl[i].c, h, cd);
            check($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
            check($sformatf("tbl%0d_code", i), cd, tbl[i].code);
            check($sformatf("tbl%0d_next", i), NextCode, tbl[i].next);
        end

        for (int i = 0; i < 150; i++)
            xact(1'($urandom_range(0, 2) == 0), {2'($urandom), 6'h0, 4'($urandom)}, 2'($urandom), h, cd);

        for (int k = 0; k < (1 << AW) && next_code < 1024; k++)
            if (!dict.exists(k)) xact(1, KW'(k >> CW), CW'(k), h, cd);
        check("full_flag", Full, 1);
        check("full_next", NextCode, 12'h400);
        xact(1, 12'h123, 2'd1, h, cd);
        check("full_insert_code", cd, 12'hFFF);
        check("full_insert_next", NextCode, 12'h400);
        xact(0, 12'h041, 2'd2, h, cd);

        ReqValid = 1; ReqOp = 0; ReqPrefix = 12'h041; ReqChar = 2'd2;
        @(negedge Clk);
        ReqValid = 0;
        check("in_read", RAMread, 1);
        #2 Reset = 1;
        #1;
        check("rst_read_drop", RAMread, 0);
        check("rst_read_ready", Ready, 0);
        check("rst_read_next", NextCode, 12'h100);
        check("rst_read_rsp", RspValid, 0);
        @(negedge Clk);
        #2 Reset = 0;
        @(negedge Clk);
        bad = 0;
        ReqValid = 1;
        repeat (10) begin
            #1 if (RspValid || ReqReady || Ready) bad++;
            @(negedge Clk);
        end
        ReqValid = 0;
        check("no_accept_before_start", bad, 0);
        do_clear();

        xact(1, 12'h010, 2'd1, h, cd);
        check("pre_start_next", NextCode, 12'h101);
        Start = 1; ReqValid = 1; ReqOp = 1; ReqPrefix = 12'h020; ReqChar = 2'd3;
        #1 check("start_blocks_req", ReqReady, 0);
        @(negedge Clk);
        Start = 0; ReqValid = 0;
        check("start_prio_rsp", RspValid, 0);
        check("start_prio_write", WriteString, 0);
        check("start_prio_next", NextCode, 12'h100);
        clear_run();
        xact(0, 12'h010, 2'd1, h, cd);
        check("cleared_entry_miss", h, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lzw_dict_ctrl.md
Name: lzw_dict_ctrl

Overview:
Sequencer for the LZW dictionary RAM. It sits between the compressor FSM and the RAM buffer.
- Clears the whole table on command.
- Serves one lookup or insert request at a time, using a valid/ready handshake.
- Owns the next-free-code counter and the RAM control strobes.
- Single-character codes 0..255 are implicit; the controller stores only multi-character strings (prefix, char).

Parameters:
ADDR_W, 18, RAM address width; table address = {prefix[ADDR_W-CHAR_W-1:0], char}
CHAR_W, 8, character width
CODE_W, 12, code width on request/response and in stored entries
FIRST_CODE, 256, first code assigned by insert
MAX_CODES, 1024, 2**(ADDR_W-CHAR_W); Full when NextCode reaches this

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  begin table clear (level sampled)
Ready  out  1  table cleared, controller usable
ReqValid  in  1  request present
ReqReady  out  1  request accepted this edge when ReqValid=1
ReqOp  in  1  0=lookup, 1=insert
ReqPrefix  in  CODE_W  prefix code; bits above ADDR_W-CHAR_W-1 ignored
ReqChar  in  CHAR_W  appended character
RspValid  out  1  one-cycle response pulse
RspHit  out  1  lookup found entry
RspCode  out  CODE_W  found/assigned code
NextCode  out  CODE_W  next free code
Full  out  1  NextCode==MAX_CODES
RAMread  out  1  RAM read strobe
RAMZeroData  out  1  RAM clear strobe
WriteString  out  1  RAM write strobe
ramDicPointer  out  ADDR_W  RAM address
ramString  out  16  write data
iRAMData  in  16  RAM read data (combinational from address)

Behaviour:
- Stored entry format: bit15 = valid, bits[14:12] = 0, bits[11:0] = code. A zeroed word means empty.
- States: WAIT, CLEAR, IDLE, READ, WRITE, RESP.
- Strobes are a Moore decode of the state and are mutually exclusive:
  - RAMZeroData=1 only in CLEAR.
  - RAMread=1 only in READ.
  - WriteString=1 only in WRITE.
  - All strobes are 0 in every other state.
- Reset (asynchronous, any time, including mid-operation):
  - state=WAIT.
  - Ready, ReqReady, RspValid, RspHit, Full, all strobes = 0.
  - RspCode, ramDicPointer, ramString = 0.
  - NextCode = FIRST_CODE.
  - RAM contents are untrusted afterwards; a Start is required before use.
- WAIT:
  - Start=1 → CLEAR, pointer=0, NextCode=FIRST_CODE.
  - Requests are not accepted.
- CLEAR:
  - One word per cycle; the pointer increments from 0 to 2**ADDR_W-1.
  - After the last word → IDLE with Ready=1.
  - Start is ignored during CLEAR.
  - Clear duration is exactly 2**ADDR_W cycles with RAMZeroData high.
- IDLE:
  - ReqReady=1.
  - Start has priority: if Start=1 (even with ReqValid=1), the request is not accepted, Ready→0, NextCode=FIRST_CODE, → CLEAR.
  - Otherwise, on ReqValid=1 the edge accepts: latch pointer={ReqPrefix[ADDR_W-CHAR_W-1:0], ReqChar}.
    - ReqOp=0 → READ.
    - ReqOp=1 and Full=0 → WRITE, with ramString={1'b1,3'b0,NextCode}.
    - ReqOp=1 and Full=1 → RESP with RspHit=0, RspCode=all ones. No write occurs.
- READ:
  - At the edge, register RspHit=iRAMData[15].
  - RspCode=iRAMData[11:0] on hit, 0 on miss.
  - → RESP.
- WRITE:
  - At the edge, RspHit=0, RspCode=NextCode, NextCode+1 → RESP.
- RESP:
  - RspValid=1 for exactly this cycle → IDLE.
  - ReqReady=0 in every state except IDLE.
- Latency: accept at edge N; RspValid is high in the cycle following edge N+1. Back-to-back requests therefore take 3 cycles each.
- RspHit/RspCode hold their value until the next response.
- Full rises combinationally-registered with NextCode. NextCode never exceeds MAX_CODES.
- Lookup or insert issued without a prior Start cannot occur: ReqReady=0 outside IDLE.

Test Plan:
1. Assert Reset mid-sequence → all outputs 0 immediately, NextCode=0x100. Release, then pulse Start → RAMZeroData high for 262144 consecutive cycles, pointer 0x00000..0x3FFFF. Ready=1 the cycle after.
2. After clear, lookup prefix=0x041, char=0x42 → RAMread with ramDicPointer=0x04142. RspValid two cycles after accept with RspHit=0, RspCode=0x000.
3. Insert prefix=0x041, char=0x42 → WriteString, ramDicPointer=0x04142, ramString=0x8100. Response RspCode=0x100, NextCode=0x101. Repeat the lookup → RspHit=1, RspCode=0x100.
4. Perform 768 distinct inserts → Full=1, NextCode=0x400. A further insert produces no WriteString pulse, RspHit=0, RspCode=0xFFF, NextCode unchanged.
5. Assert Reset while in READ → RAMread drops asynchronously, no RspValid, Ready=0, ReqReady stays 0 until Start and a full clear complete.
6. In IDLE, drive Start=1 with ReqValid=1 the same cycle → request not accepted (no RspValid), CLEAR begins, NextCode=0x100.
